// File: rtl/ysyx_24100006_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: bus widths and FSM state encoding.
package ysyx_24100006_mem_arbiter_pkg;

   localparam int unsigned ARB_ADDR_W = 32;
   localparam int unsigned ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IFU_RD = 2'd1,
      ST_LSU_RD = 2'd2,
      ST_LSU_WR = 2'd3
   } arb_state_e;

endpackage

// File: rtl/ysyx_24100006_rr_pick2.sv
// Two-way round-robin selector; req[0] wins a tie when it was not the most recent winner.
module ysyx_24100006_rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) begin
         grant = last ? 2'b10 : 2'b01;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/ysyx_24100006_mem_arbiter.sv
// Shares one AXI-lite-style memory slave between the IFU (read) and the LSU (read/write),
// one outstanding transaction at a time, round-robin on contention.
module ysyx_24100006_mem_arbiter
   import ysyx_24100006_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ARB_ADDR_W,
   parameter int unsigned DATA_W = ARB_DATA_W
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                ifu_arvalid,
   input  logic [ADDR_W-1:0]   ifu_araddr,
   output logic                ifu_arready,
   output logic                ifu_rvalid,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                ifu_rready,

   input  logic                lsu_arvalid,
   input  logic [ADDR_W-1:0]   lsu_araddr,
   output logic                lsu_arready,
   output logic                lsu_rvalid,
   output logic [DATA_W-1:0]   lsu_rdata,
   input  logic                lsu_rready,
   input  logic                lsu_awvalid,
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   output logic                lsu_awready,
   input  logic                lsu_wvalid,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   output logic                lsu_wready,
   output logic                lsu_bvalid,
   input  logic                lsu_bready,

   output logic                mem_arvalid,
   output logic [ADDR_W-1:0]   mem_araddr,
   input  logic                mem_arready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_rready,
   output logic                mem_awvalid,
   output logic [ADDR_W-1:0]   mem_awaddr,
   input  logic                mem_awready,
   output logic                mem_wvalid,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_wready,
   input  logic                mem_bvalid,
   output logic                mem_bready
);

   arb_state_e state_q, state_d;
   logic       last_ifu_q, last_ifu_d;
   logic [1:0] req;
   logic [1:0] grant;

   assign req = {lsu_arvalid | lsu_awvalid, ifu_arvalid};

   ysyx_24100006_rr_pick2 u_pick (
      .req   (req),
      .last  (last_ifu_q),
      .grant (grant)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         last_ifu_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_ifu_q <= last_ifu_d;
      end
   end

   // Next state plus grant-based routing; everything idles at zero outside its grant.
   always_comb begin
      state_d     = state_q;
      last_ifu_d  = last_ifu_q;
      ifu_arready = 1'b0;
      ifu_rvalid  = 1'b0;
      ifu_rdata   = '0;
      lsu_arready = 1'b0;
      lsu_rvalid  = 1'b0;
      lsu_rdata   = '0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bvalid  = 1'b0;
      mem_arvalid = 1'b0;
      mem_araddr  = '0;
      mem_rready  = 1'b0;
      mem_awvalid = 1'b0;
      mem_awaddr  = '0;
      mem_wvalid  = 1'b0;
      mem_wdata   = '0;
      mem_wstrb   = '0;
      mem_bready  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grant[0]) begin
               state_d    = ST_IFU_RD;
               last_ifu_d = 1'b1;
            end else if (grant[1]) begin
               // A pending write outranks a pending read from the same master.
               state_d    = lsu_awvalid ? ST_LSU_WR : ST_LSU_RD;
               last_ifu_d = 1'b0;
            end
         end
         ST_IFU_RD: begin
            mem_arvalid = ifu_arvalid;
            mem_araddr  = ifu_araddr;
            ifu_arready = mem_arready;
            ifu_rvalid  = mem_rvalid;
            ifu_rdata   = mem_rdata;
            mem_rready  = ifu_rready;
            if (mem_rvalid && ifu_rready) state_d = ST_IDLE;
         end
         ST_LSU_RD: begin
            mem_arvalid = lsu_arvalid;
            mem_araddr  = lsu_araddr;
            lsu_arready = mem_arready;
            lsu_rvalid  = mem_rvalid;
            lsu_rdata   = mem_rdata;
            mem_rready  = lsu_rready;
            if (mem_rvalid && lsu_rready) state_d = ST_IDLE;
         end
         ST_LSU_WR: begin
            mem_awvalid = lsu_awvalid;
            mem_awaddr  = lsu_awaddr;
            lsu_awready = mem_awready;
            mem_wvalid  = lsu_wvalid;
            mem_wdata   = lsu_wdata;
            mem_wstrb   = lsu_wstrb;
            lsu_wready  = mem_wready;
            lsu_bvalid  = mem_bvalid;
            mem_bready  = lsu_bready;
            if (mem_bvalid && lsu_bready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
